// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t    : loader FSM states
//   SYNC_BYTE  : frame start marker
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCntLo,
    StCntHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the UART byte stream, the loader, and the imem write port.
//   rx_data/rx_valid        : received byte and its one-cycle strobe
//   imem_we/addr/wdata      : imem word write port
//   core_hold/load_done/err : core control and load status
// Modports:
//   master : the loader (drives imem port and status, consumes rx stream)
//   slave  : the environment (drives rx stream, observes imem port and status)
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 5
) ();

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    input  rx_data,
    input  rx_valid,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output core_hold,
    output load_done,
    output load_err
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  core_hold,
    input  load_done,
    input  load_err
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_clear       : restart at byte 0 of a new word
//   i_valid       : i_byte is valid this cycle
//   i_byte        : incoming byte
//   o_word        : assembled word, valid while o_word_ready is high
//   o_word_ready  : high in the cycle the 4th byte of a word is presented
module imem_loader_word_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  // Holds the three earlier bytes; the 4th byte completes the word combinationally.
  logic [23:0] r_buf;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_valid) begin
      r_buf <= {i_byte, r_buf[23:8]};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_word       = {i_byte, r_buf};
  assign o_word_ready = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses SYNC, 16-bit LE word count, 4*N data bytes
// and an XOR checksum from the UART byte stream, writes each word into imem and
// holds the core until a checksum-valid image is in place.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : rx stream in, imem write port / core_hold / status out
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  imem_loader_if.master bus
);

  localparam logic [16:0] Capacity = 17'(2 ** ADDR_W);

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic [15:0]       r_idx;
  logic [7:0]        r_csum;
  logic [31:0]       r_to;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_done;
  logic              r_err;

  logic        w_sync;
  logic        w_restart;
  logic        w_active;
  logic        w_pack_valid;
  logic [31:0] w_word;
  logic        w_word_ready;
  logic [15:0] w_n;

  assign w_sync       = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  // A new frame may only start from the idle/terminal states; SYNC elsewhere is data.
  assign w_restart    = w_sync && (r_state inside {StIdle, StDone, StErr});
  assign w_active     = r_state inside {StCntLo, StCntHi, StData, StCsum};
  assign w_pack_valid = bus.rx_valid && (r_state == StData);
  assign w_n          = {bus.rx_data, r_cnt[7:0]};

  imem_loader_word_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_restart),
    .i_valid      (w_pack_valid),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
      r_to    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;

      if (w_active) begin
        r_to <= bus.rx_valid ? '0 : r_to + 32'd1;
      end else begin
        r_to <= '0;
      end

      unique case (r_state)
        StIdle, StDone, StErr: begin
          if (w_restart) begin
            r_state <= StCntLo;
            r_csum  <= '0;
            r_idx   <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        StCntLo: begin
          if (bus.rx_valid) begin
            r_cnt[7:0] <= bus.rx_data;
            r_state    <= StCntHi;
          end
        end
        StCntHi: begin
          if (bus.rx_valid) begin
            r_cnt <= w_n;
            if ({1'b0, w_n} > Capacity) begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end else if (w_n == 16'd0) begin
              r_state <= StCsum;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (bus.rx_valid) begin
            r_csum <= r_csum ^ bus.rx_data;
          end
          if (w_word_ready) begin
            r_we    <= 1'b1;
            r_addr  <= r_idx[ADDR_W-1:0];
            r_wdata <= w_word;
            r_idx   <= r_idx + 16'd1;
            if (r_idx == r_cnt - 16'd1) begin
              r_state <= StCsum;
            end
          end
        end
        StCsum: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == r_csum) begin
              r_state <= StDone;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase

      // Timeout only fires on an idle cycle, so it never collides with a byte action above.
      if (w_active && !bus.rx_valid && (r_to == TIMEOUT_CYC - 1)) begin
        r_state <= StErr;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_hold  = r_hold;
  assign bus.load_done  = r_done;
  assign bus.load_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned TIMEOUT_CYC = 50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  wr_t exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.imem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: addr %0d data 0x%08h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.imem_addr === e.addr && bus.imem_wdata === e.data) begin
          n_pass++;
        end else begin
          $display("FAIL write: addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                   bus.imem_addr, bus.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic expect_wr(input int unsigned a, input logic [31:0] d);
    wr_t e;
    e.addr = a[ADDR_W-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done,
                              input logic err);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_hold"}, {31'd0, bus.core_hold}, {31'd0, hold});
    check({tag, "_done"}, {31'd0, bus.load_done}, {31'd0, done});
    check({tag, "_err"}, {31'd0, bus.load_err}, {31'd0, err});
  endtask

  // Two-word frame; checksum is the XOR of the eight data bytes: 0x08 ^ 0x22 = 0x2A.
  task automatic send_two_word_frame(input logic [7:0] csum);
    logic [7:0] fr [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    expect_wr(0, 32'h1234_5678);
    expect_wr(1, 32'hDEAD_BEEF);
    foreach (fr[i]) send_byte(fr[i]);
    send_byte(csum);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset values, then junk bytes in IDLE are ignored.
    check("rst_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check_status("rst", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(2);
    check_status("junk", 1'b1, 1'b0, 1'b0);

    // Good two-word frame.
    send_two_word_frame(8'h2A);
    idle(3);
    check_status("good", 1'b0, 1'b1, 1'b0);

    // Same frame, bad checksum: writes still happen, load errors.
    send_two_word_frame(8'h00);
    idle(3);
    check_status("badcsum", 1'b1, 1'b0, 1'b1);

    // N = 33 overflows a 32-word imem.
    send_byte(8'hA5);
    send_byte(8'h21);
    send_byte(8'h00);
    idle(2);
    check_status("ovf", 1'b1, 1'b0, 1'b1);

    // Exactly full: 32 words of {4{k}}, checksum of all bytes is 0.
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h00);
    check("full_err_cleared", {31'd0, bus.load_err}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      expect_wr(k, {4{8'(k)}});
      repeat (4) send_byte(8'(k));
    end
    send_byte(8'h00);
    idle(3);
    check_status("full", 1'b0, 1'b1, 1'b0);

    // Stall mid-word: no error before the timeout, error after it.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TIMEOUT_CYC - 20);
    check_status("to_before", 1'b1, 1'b0, 1'b0);
    idle(30);
    check_status("to_after", 1'b1, 1'b0, 1'b1);
    send_two_word_frame(8'h2A);
    idle(3);
    check_status("to_recover", 1'b0, 1'b1, 1'b0);

    // Reset mid-load, then an empty frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    check("mid_rst_we", {31'd0, bus.imem_we}, 32'd0);
    check_status("mid_rst", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(3);
    check_status("empty", 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
